// File: rtl/pipeline_control_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_control_pkg
// Shared types and constants for the MEM-stage sequencer of the RISC-V core.
//   mem_state_e     : MEM-stage FSM states (IDLE, REQUEST, COMPLETE)
//   fault_cause_e   : 3-bit fault cause encodings reported on faultCause
//   WORD_ALIGN_MASK : address LSBs that must be zero for a word access
//   is_word_aligned : helper applying WORD_ALIGN_MASK to an address LSB pair
// -----------------------------------------------------------------------------
package pipeline_control_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQUEST  = 2'd1,
    COMPLETE = 2'd2
  } mem_state_e;

  typedef enum logic [2:0] {
    CAUSE_NONE       = 3'd0,
    CAUSE_MISALIGNED = 3'd1,
    CAUSE_CONFLICT   = 3'd2,
    CAUSE_BUS_ERROR  = 3'd3,
    CAUSE_TIMEOUT    = 3'd4
  } fault_cause_e;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  function automatic logic is_word_aligned(input logic [1:0] addr_lsbs);
    return (addr_lsbs & WORD_ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/access_timeout_counter.sv
// -----------------------------------------------------------------------------
// access_timeout_counter
// Counts cycles spent waiting on the data memory and flags the last allowed
// wait cycle. Only instantiated when ACCESS_TIMEOUT_EN is defined.
// Ports:
//   clock   in  single clock, all state on posedge
//   reset   in  synchronous, active-low
//   clear   in  return count to zero (held while not waiting)
//   enable  in  count this cycle (high while waiting)
//   expired out high during the TIMEOUT_CYCLES-th enabled cycle since clear
// -----------------------------------------------------------------------------
module access_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  // The count stops at LAST_COUNT so it can never wrap back to zero while
  // the owner is still deciding what to do with the expiry.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LAST_COUNT)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // First enabled cycle sees count 0, so the N-th sees N-1.
  assign expired = enable && (count_q == LAST_COUNT);

endmodule

// File: rtl/memory_stage_controller.sv
// -----------------------------------------------------------------------------
// memory_stage_controller
// MEM-stage sequencer: takes the load/store in EX/MEM, runs a request/ready
// handshake with a variable-latency data memory, stalls upstream and bubbles
// MEM/WB while the access is outstanding, and hands load data or a fault
// indication to write-back.
// Optional feature macro: ACCESS_TIMEOUT_EN (abort a wait after
// TIMEOUT_CYCLES cycles with fault cause 4). Undefined: waits indefinitely.
// Ports:
//   clock, reset             single clock; synchronous active-low reset
//   memRead, memWrite        load / store present in MEM
//   memAddress, memWriteData effective address and store data
//   dmemRequest              request to data memory (REQUEST state)
//   dmemWriteEnable          1 = write, valid with dmemRequest
//   dmemAddress, dmemWriteData registered copies of address / store data
//   dmemReady, dmemError, dmemReadData  memory response (qualified by ready)
//   stallPipeline            hold PC, IF/ID, ID/EX, EX/MEM
//   bubbleWriteBack          MEM/WB loads a NOP
//   memoryReadDataOut        captured load data (0 on fault)
//   accessFault, faultCause  one-cycle fault pulse and sticky cause
// -----------------------------------------------------------------------------
module memory_stage_controller
  import pipeline_control_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  memRead,
  input  logic                  memWrite,
  input  logic [ADDR_WIDTH-1:0] memAddress,
  input  logic [DATA_WIDTH-1:0] memWriteData,
  output logic                  dmemRequest,
  output logic                  dmemWriteEnable,
  output logic [ADDR_WIDTH-1:0] dmemAddress,
  output logic [DATA_WIDTH-1:0] dmemWriteData,
  input  logic                  dmemReady,
  input  logic                  dmemError,
  input  logic [DATA_WIDTH-1:0] dmemReadData,
  output logic                  stallPipeline,
  output logic                  bubbleWriteBack,
  output logic [DATA_WIDTH-1:0] memoryReadDataOut,
  output logic                  accessFault,
  output logic [2:0]            faultCause
);

  mem_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  write_q, write_d;
  fault_cause_e          pending_q, pending_d;  // fault to report in COMPLETE
  fault_cause_e          cause_q, cause_d;      // last reported cause (sticky)
  fault_cause_e          fault_now;             // cause shown this cycle
  logic                  timeout_expired;

  // ---------------------------------------------------------------------------
  // Request decode (only meaningful in IDLE)
  // ---------------------------------------------------------------------------
  logic access_seen, conflict, aligned, misaligned, legal_access;

  assign access_seen  = memRead || memWrite;
  assign conflict     = memRead && memWrite;
  assign aligned      = is_word_aligned(memAddress[1:0]);
  // A conflict takes precedence over misalignment when both apply.
  assign misaligned   = access_seen && !conflict && !aligned;
  assign legal_access = access_seen && !conflict && aligned;

  // ---------------------------------------------------------------------------
  // Optional wait-cycle limit
  // ---------------------------------------------------------------------------
`ifdef ACCESS_TIMEOUT_EN
  access_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  (state_q != REQUEST),
    .enable (state_q == REQUEST),
    .expired(timeout_expired)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout_expired    = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (legal_access) state_d = REQUEST;
      // A ready arriving on the expiry cycle is a normal completion.
      REQUEST:  if (dmemReady || timeout_expired) state_d = COMPLETE;
      COMPLETE: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    dmemRequest     = 1'b0;
    dmemWriteEnable = 1'b0;
    stallPipeline   = 1'b0;
    bubbleWriteBack = 1'b0;
    accessFault     = 1'b0;
    fault_now       = cause_q;
    case (state_q)
      IDLE: begin
        if (conflict) begin
          accessFault = 1'b1;
          fault_now   = CAUSE_CONFLICT;
        end else if (misaligned) begin
          accessFault = 1'b1;
          fault_now   = CAUSE_MISALIGNED;
        end else if (legal_access) begin
          // Stall in the same cycle the access is seen so EX/MEM holds it.
          stallPipeline   = 1'b1;
          bubbleWriteBack = 1'b1;
        end
      end
      REQUEST: begin
        dmemRequest     = 1'b1;
        dmemWriteEnable = write_q;
        stallPipeline   = 1'b1;
        bubbleWriteBack = 1'b1;
      end
      COMPLETE: begin
        if (pending_q != CAUSE_NONE) begin
          accessFault = 1'b1;
          fault_now   = pending_q;
        end
      end
      default: ;
    endcase
    // Reset low overrides every control output regardless of inputs.
    if (!reset) begin
      dmemRequest     = 1'b0;
      dmemWriteEnable = 1'b0;
      stallPipeline   = 1'b0;
      bubbleWriteBack = 1'b0;
      accessFault     = 1'b0;
      fault_now       = CAUSE_NONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------------
  always_comb begin
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    rdata_d   = rdata_q;
    pending_d = pending_q;
    cause_d   = cause_q;
    case (state_q)
      IDLE: begin
        pending_d = CAUSE_NONE;
        if (legal_access) begin
          addr_d  = memAddress;
          wdata_d = memWriteData;
          write_d = memWrite;
        end
      end
      REQUEST: begin
        if (dmemReady) begin
          if (dmemError) begin
            rdata_d   = '0;
            pending_d = CAUSE_BUS_ERROR;
          end else if (!write_q) begin
            rdata_d = dmemReadData;
          end
        end else if (timeout_expired) begin
          rdata_d   = '0;
          pending_d = CAUSE_TIMEOUT;
        end
      end
      default: ;
    endcase
    // The cause register follows whatever fault is pulsed, so it shows the
    // new cause from the pulse cycle onwards and holds it afterwards.
    if (accessFault) begin
      cause_d = fault_now;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      rdata_q   <= '0;
      pending_q <= CAUSE_NONE;
      cause_q   <= CAUSE_NONE;
    end else begin
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      rdata_q   <= rdata_d;
      pending_q <= pending_d;
      cause_q   <= cause_d;
    end
  end

  assign dmemAddress       = addr_q;
  assign dmemWriteData     = wdata_q;
  assign memoryReadDataOut = rdata_q;
  assign faultCause        = fault_now;

endmodule

// File: doc/memory_stage_controller.md
# memory_stage_controller

Sequencer for the MEM stage of the pipelined RISC-V core. It takes the load/store request held in the execute-to-memory pipeline register and runs a ready/request handshake with a variable-latency data memory. While the access is outstanding it holds the upstream pipeline registers and bubbles the memory-to-write-back register. It delivers captured load data, or a fault indication, to write-back.

## Interface
Parameters:
- ADDR_WIDTH, 32, data-memory address width
- DATA_WIDTH, 32, data width
- TIMEOUT_CYCLES, 64, wait cycles before abort (used only with ACCESS_TIMEOUT_EN)

Ports:
- clock  in  1  single clock, all state on posedge
- reset  in  1  synchronous, active-low
- memRead  in  1  load in MEM stage
- memWrite  in  1  store in MEM stage
- memAddress  in  ADDR_WIDTH  effective address from ALU
- memWriteData  in  DATA_WIDTH  store data
- dmemRequest  out  1  access request to data memory
- dmemWriteEnable  out  1  1 = write, 0 = read; valid with dmemRequest
- dmemAddress  out  ADDR_WIDTH  registered address
- dmemWriteData  out  DATA_WIDTH  registered store data
- dmemReady  in  1  memory completes the access this cycle
- dmemError  in  1  bus error, qualified by dmemReady
- dmemReadData  in  DATA_WIDTH  read data, qualified by dmemReady
- stallPipeline  out  1  hold PC, IF/ID, ID/EX and EX/MEM registers
- bubbleWriteBack  out  1  MEM/WB register loads a NOP
- memoryReadDataOut  out  DATA_WIDTH  captured load data
- accessFault  out  1  one-cycle fault pulse
- faultCause  out  3  0 none, 1 misaligned, 2 read/write conflict, 3 bus error, 4 timeout

## Operation
- FSM states: IDLE, REQUEST, COMPLETE.
- IDLE, legal access (exactly one of memRead/memWrite, memAddress[1:0]==0):
  - latch address, data and direction;
  - assert stallPipeline and bubbleWriteBack;
  - go to REQUEST.
- IDLE, memRead and memWrite both high: accessFault=1, faultCause=2, no request, no stall, stay IDLE.
- IDLE, misaligned address: accessFault=1, faultCause=1, no request, no stall, stay IDLE.
- REQUEST:
  - dmemRequest=1, stallPipeline=1, bubbleWriteBack=1;
  - request and latched fields are held stable until dmemReady.
- REQUEST with dmemReady:
  - capture dmemReadData into memoryReadDataOut (reads only; stores leave it unchanged);
  - go to COMPLETE.
- REQUEST with dmemReady and dmemError:
  - memoryReadDataOut=0;
  - go to COMPLETE with a pending fault, cause 3.
- COMPLETE:
  - stallPipeline=0, bubbleWriteBack=0, so EX/MEM advances and MEM/WB captures the result;
  - a pending fault pulses accessFault in this cycle;
  - go to IDLE unconditionally.
- faultCause holds the last cause until the next fault; it is cleared only by reset.

## Timing
- Reset (reset==0 at an edge):
  - state=IDLE;
  - dmemRequest, dmemWriteEnable, stallPipeline, bubbleWriteBack and accessFault are 0;
  - dmemAddress, dmemWriteData, memoryReadDataOut = 0; faultCause=0.
  - While reset is low, all control outputs are forced to 0 regardless of inputs.
- Reset mid-access: the request drops at that edge, the pending fault is discarded and no stale data is delivered.
- Access visible in IDLE at cycle t:
  - stall is asserted combinationally at t;
  - dmemRequest rises at t+1;
  - if dmemReady at t+k (k≥1): COMPLETE at t+k+1, stall low at t+k+1.
  - Minimum occupancy is 3 cycles, with stall high for 2 cycles.
- Back-to-back accesses: the next access is seen in IDLE at t+k+2. There is exactly one non-stalled cycle between accesses (the COMPLETE cycle).
- dmemReady outside REQUEST is ignored.
- Non-memory instructions in IDLE pass with zero stall.

## Configuration
- Macro: ACCESS_TIMEOUT_EN.
- Defined:
  - a cycle counter runs in REQUEST, cleared on entry;
  - after TIMEOUT_CYCLES cycles without dmemReady, dmemRequest drops, memoryReadDataOut=0, and the FSM goes to COMPLETE with fault cause 4.
  - dmemReady arriving in the same cycle as expiry wins: normal completion, no fault.
- Undefined: no counter logic; REQUEST waits indefinitely; cause 4 is never produced.

## Structure
- Shared package pipeline_control_pkg:
  - state enum (IDLE, REQUEST, COMPLETE);
  - fault cause enum (3-bit encodings above);
  - alignment mask constant.
- Sub-module access_timeout_counter: clear, enable, expired outputs; parameterised by TIMEOUT_CYCLES. It is instantiated only under ACCESS_TIMEOUT_EN.

## Test plan
- Load: memRead=1, memAddress=0x100, dmemReady one cycle after request, dmemReadData=0xDEADBEEF -> stall for 2 cycles, memoryReadDataOut=0xDEADBEEF in COMPLETE, no fault.
- Store: memWrite=1, memAddress=0x204, memWriteData=0x12345678, ready after 5 wait cycles -> dmemWriteEnable=1 and address/data stable throughout, stall for 6 cycles.
- Misaligned load to 0x103 -> accessFault pulse, faultCause=1, dmemRequest never rises, stall 0. Conflict (both high) -> faultCause=2.
- Bus error: ready with dmemError=1 -> memoryReadDataOut=0, accessFault in COMPLETE, faultCause=3.
- Reset low during REQUEST -> next cycle all outputs 0, state IDLE, no fault pulse.
- With ACCESS_TIMEOUT_EN and TIMEOUT_CYCLES=4, memory never ready -> request drops after 4 cycles, faultCause=4, then a normal access succeeds.
